// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM stage of a 5-stage RV32I pipeline. It sits between the
//             EX/MEM and MEM/WB latches. Loads and stores go over a shared
//             byte-wide RAM port, one byte per granted cycle. While the access
//             is in progress the stage holds the pipeline. Non-memory ops pass
//             through to MEM/WB combinationally.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             aluop_i             - EX opcode (load/store ops or ME_NOP_OP)
//             mem_addr_i          - effective byte address
//             wdata_i             - store data / ALU result
//             wd_i, wreg_i        - destination register and write enable
//             wd_o, wreg_o,
//             wdata_o             - writeback bundle to MEM/WB
//             stall_req_o         - stall request to pipeline control
//             mem_req_o, mem_gnt_i- RAM port request / grant
//             mem_a_o, mem_dout_o,
//             mem_wr_o, mem_din_i - RAM byte address, write byte, write
//                                   strobe, read byte (valid one cycle after
//                                   a granted read)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int OP_W  = 8,
    parameter int MAX_B = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] aluop_i,
    input  logic [31:0]     mem_addr_i,
    input  logic [31:0]     wdata_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [31:0]     wdata_o,
    output logic            stall_req_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [31:0]     mem_a_o,
    output logic [7:0]      mem_dout_o,
    output logic            mem_wr_o,
    input  logic [7:0]      mem_din_i
);

    // ------------------------------------------------------------------
    // Opcode encodings shared with the EX stage
    // ------------------------------------------------------------------
    localparam logic [OP_W-1:0] c_ME_NOP_OP = OP_W'(8'h00);
    localparam logic [OP_W-1:0] c_EX_LB_OP  = OP_W'(8'h20);
    localparam logic [OP_W-1:0] c_EX_LH_OP  = OP_W'(8'h21);
    localparam logic [OP_W-1:0] c_EX_LW_OP  = OP_W'(8'h22);
    localparam logic [OP_W-1:0] c_EX_LBU_OP = OP_W'(8'h24);
    localparam logic [OP_W-1:0] c_EX_LHU_OP = OP_W'(8'h25);
    localparam logic [OP_W-1:0] c_EX_SB_OP  = OP_W'(8'h28);
    localparam logic [OP_W-1:0] c_EX_SH_OP  = OP_W'(8'h29);
    localparam logic [OP_W-1:0] c_EX_SW_OP  = OP_W'(8'h2A);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [2:0]        r_cnt;       // bytes granted so far
    logic              r_rd_pend;   // a read byte arrives on mem_din_i this cycle
    logic [31:0]       r_buf;       // load assembly buffer
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [OP_W-1:0]   r_op;
    logic [2:0]        r_nbytes;
    logic              r_is_store;
    logic [4:0]        r_wd;
    logic              r_wreg;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    function automatic logic [2:0] f_nbytes(input logic [OP_W-1:0] op);
        logic [2:0] n;
        n = 3'd0;
        if (op == c_EX_LB_OP || op == c_EX_LBU_OP || op == c_EX_SB_OP)
            n = 3'd1;
        else if (op == c_EX_LH_OP || op == c_EX_LHU_OP || op == c_EX_SH_OP)
            n = 3'd2;
        else if (op == c_EX_LW_OP || op == c_EX_SW_OP)
            n = 3'(MAX_B);
        return n;
    endfunction

    logic [2:0]  w_in_nbytes;
    logic        w_in_is_mem;
    logic        w_in_is_store;
    logic        w_last_byte;
    logic [1:0]  w_cap_idx;
    logic [7:0]  w_st_byte;
    logic [31:0] w_ld_data;

    assign w_in_nbytes   = f_nbytes(aluop_i);
    assign w_in_is_mem   = (w_in_nbytes != 3'd0);
    assign w_in_is_store = (aluop_i == c_EX_SB_OP) || (aluop_i == c_EX_SH_OP) ||
                           (aluop_i == c_EX_SW_OP);
    assign w_last_byte   = ((r_cnt + 3'd1) == r_nbytes);
    // r_cnt has already advanced past the byte whose data is arriving now
    assign w_cap_idx     = r_cnt[1:0] - 2'd1;
    assign w_st_byte     = r_wdata[{r_cnt[1:0], 3'b000} +: 8];

    always_comb begin
        w_ld_data = r_buf;
        if (r_op == c_EX_LB_OP)
            w_ld_data = {{24{r_buf[7]}}, r_buf[7:0]};
        else if (r_op == c_EX_LBU_OP)
            w_ld_data = {24'd0, r_buf[7:0]};
        else if (r_op == c_EX_LH_OP)
            w_ld_data = {{16{r_buf[15]}}, r_buf[15:0]};
        else if (r_op == c_EX_LHU_OP)
            w_ld_data = {16'd0, r_buf[15:0]};
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_rd_pend  <= 1'b0;
            r_buf      <= 32'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_op       <= c_ME_NOP_OP;
            r_nbytes   <= 3'd0;
            r_is_store <= 1'b0;
            r_wd       <= 5'd0;
            r_wreg     <= 1'b0;
        end else begin
            r_rd_pend <= 1'b0;
            // Read capture runs regardless of the current grant
            if (r_rd_pend)
                r_buf[{w_cap_idx, 3'b000} +: 8] <= mem_din_i;

            case (r_state)
                S_IDLE: begin
                    if (w_in_is_mem) begin
                        r_addr     <= mem_addr_i;
                        r_wdata    <= wdata_i;
                        r_op       <= aluop_i;
                        r_nbytes   <= w_in_nbytes;
                        r_is_store <= w_in_is_store;
                        r_wd       <= wd_i;
                        r_wreg     <= wreg_i;
                        r_cnt      <= 3'd0;
                        r_buf      <= 32'd0;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_gnt_i) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (!r_is_store)
                            r_rd_pend <= 1'b1;
                        if (w_last_byte)
                            r_state <= r_is_store ? S_DONE : S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: combinational from state and registers, forced low in reset
    // ------------------------------------------------------------------
    always_comb begin
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        stall_req_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_a_o     = 32'd0;
        mem_dout_o  = 8'd0;
        mem_wr_o    = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_is_mem) begin
                        stall_req_o = 1'b1;
                    end else begin
                        wd_o = wd_i;
                        // x0 is never written: drop the write and its data
                        if (!(wreg_i && wd_i == 5'd0)) begin
                            wreg_o  = wreg_i;
                            wdata_o = wdata_i;
                        end
                    end
                end
                S_ACCESS: begin
                    stall_req_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_a_o     = r_addr + {29'd0, r_cnt};
                    mem_wr_o    = r_is_store;
                    mem_dout_o  = w_st_byte;
                end
                S_RD_WAIT: begin
                    stall_req_o = 1'b1;
                end
                S_DONE: begin
                    wd_o = r_wd;
                    if (!r_is_store && !(r_wreg && r_wd == 5'd0)) begin
                        wreg_o  = r_wreg;
                        wdata_o = w_ld_data;
                    end
                end
                default: begin
                    stall_req_o = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage. A byte RAM model answers the
//             port; expected results come from a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam logic [7:0] c_NOP = 8'h00;
    localparam logic [7:0] c_LB  = 8'h20;
    localparam logic [7:0] c_LH  = 8'h21;
    localparam logic [7:0] c_LW  = 8'h22;
    localparam logic [7:0] c_LBU = 8'h24;
    localparam logic [7:0] c_LHU = 8'h25;
    localparam logic [7:0] c_SB  = 8'h28;
    localparam logic [7:0] c_SH  = 8'h29;
    localparam logic [7:0] c_SW  = 8'h2A;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic [7:0]  mem_din_i;

    mem_stage #(.OP_W(8), .MAX_B(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .mem_addr_i (mem_addr_i),
        .wdata_i    (wdata_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stall_req_o(stall_req_o),
        .mem_req_o  (mem_req_o),
        .mem_gnt_i  (mem_gnt_i),
        .mem_a_o    (mem_a_o),
        .mem_dout_o (mem_dout_o),
        .mem_wr_o   (mem_wr_o),
        .mem_din_i  (mem_din_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // RAM model with access logs
    // ------------------------------------------------------------------
    logic [7:0]  ram [logic [31:0]];
    int unsigned cycle = 0;
    logic [31:0] wr_a[$];
    logic [7:0]  wr_d[$];
    int unsigned wr_c[$];
    logic [31:0] rd_a[$];
    int unsigned rd_c[$];

    function automatic logic [7:0] rd_ram(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        if (mem_req_o && mem_gnt_i) begin
            if (mem_wr_o) begin
                ram[mem_a_o] = mem_dout_o;
                wr_a.push_back(mem_a_o);
                wr_d.push_back(mem_dout_o);
                wr_c.push_back(cycle);
                mem_din_i <= 8'($urandom);
            end else begin
                mem_din_i <= rd_ram(mem_a_o);
                rd_a.push_back(mem_a_o);
                rd_c.push_back(cycle);
            end
        end else begin
            mem_din_i <= 8'($urandom);
        end
    end

    // Grant pattern indexed by cycle within a transaction (0 = arrival cycle)
    int g[64];

    task automatic grant_full();
        for (int i = 0; i < 64; i++) g[i] = 1;
    endtask

    task automatic grant_rand();
        for (int i = 0; i < 64; i++) g[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
        for (int i = 56; i < 64; i++) g[i] = 1;
    endtask

    function automatic int op_bytes(input logic [7:0] op);
        case (op)
            c_LB, c_LBU, c_SB: return 1;
            c_LH, c_LHU, c_SH: return 2;
            c_LW, c_SW:        return 4;
            default:           return 0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // One transaction: drive, wait for stall release, compare with model.
    // Entered and left one time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] wd,
                          input logic wreg);
        int          n;
        bit          is_ld, is_st;
        logic [31:0] v;
        logic [31:0] exp_data;
        logic        exp_wreg;
        int          pos[4];
        int          k;
        int          exp_stall;
        int          stalls;
        int          cyc;
        int unsigned c0;
        bit          timeout;

        n     = op_bytes(op);
        is_st = (op == c_SB) || (op == c_SH) || (op == c_SW);
        is_ld = (n != 0) && !is_st;

        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd_ram(addr + 32'(i));
        case (op)
            c_LB:    v = 32'($signed(v[7:0]));
            c_LH:    v = 32'($signed(v[15:0]));
            c_LBU:   v = {24'd0, v[7:0]};
            c_LHU:   v = {16'd0, v[15:0]};
            c_LW:    v = v;
            default: v = data;
        endcase
        if (is_st || (wreg && wd == 5'd0)) begin
            exp_wreg = 1'b0;
            exp_data = 32'd0;
        end else begin
            exp_wreg = wreg;
            exp_data = v;
        end

        k = 0;
        for (int i = 1; i < 64; i++) begin
            if (g[i] != 0 && k < n) begin
                pos[k] = i;
                k++;
            end
        end
        exp_stall = (n == 0) ? 0 : 1 + pos[n-1] + (is_ld ? 1 : 0);

        wr_a.delete(); wr_d.delete(); wr_c.delete();
        rd_a.delete(); rd_c.delete();

        aluop_i    = op;
        mem_addr_i = addr;
        wdata_i    = data;
        wd_i       = wd;
        wreg_i     = wreg;
        mem_gnt_i  = g[0][0];
        c0         = cycle;
        stalls     = 0;
        cyc        = 0;
        timeout    = 0;
        while (1) begin
            #1;
            if (!stall_req_o) break;
            stalls++;
            if (stalls > 40) begin
                timeout = 1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            mem_gnt_i = g[cyc][0];
        end
        chk("timeout", 32'(timeout), 32'd0);
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        chk("wdata_o", wdata_o, exp_data);
        chk("wreg_o", {31'd0, wreg_o}, {31'd0, exp_wreg});
        chk("wd_o", {27'd0, wd_o}, {27'd0, wd});
        chk("mem_req_done", {31'd0, mem_req_o}, 32'd0);

        @(posedge clk);
        #1;
        aluop_i = c_NOP;
        wreg_i  = 1'b0;

        chk("n_writes", 32'(wr_a.size()), is_st ? 32'(n) : 32'd0);
        chk("n_reads", 32'(rd_a.size()), is_ld ? 32'(n) : 32'd0);
        for (int j = 0; j < n && j < wr_a.size(); j++) begin
            chk("wr_addr", wr_a[j], addr + 32'(j));
            chk("wr_byte", {24'd0, wr_d[j]}, {24'd0, data[8*j +: 8]});
            chk("wr_cycle", wr_c[j] - c0, 32'(pos[j]));
        end
        for (int j = 0; j < n && j < rd_a.size(); j++) begin
            chk("rd_addr", rd_a[j], addr + 32'(j));
            chk("rd_cycle", rd_c[j] - c0, 32'(pos[j]));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
        chk({tag, "_addr"}, mem_a_o, 32'd0);
        chk({tag, "_misc"},
            {15'd0, wd_o, wreg_o, stall_req_o, mem_req_o, mem_wr_o, mem_dout_o}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] ops[9];
        logic [7:0] op;
        logic [31:0] a;

        ops = '{c_NOP, c_LB, c_LH, c_LW, c_LBU, c_LHU, c_SB, c_SH, c_SW};
        rst        = 1'b1;
        aluop_i    = c_LW;
        mem_addr_i = 32'h100;
        wdata_i    = 32'hFFFF_FFFF;
        wd_i       = 5'd3;
        wreg_i     = 1'b1;
        mem_gnt_i  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        aluop_i = c_NOP;
        wreg_i  = 1'b0;
        @(posedge clk);
        #1;

        // Pass-through
        grant_full();
        run_op(c_NOP, 32'h0, 32'h1234_5678, 5'd5, 1'b1);

        // Word load, full grant
        ram[32'h100] = 8'h78; ram[32'h101] = 8'h56;
        ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
        run_op(c_LW, 32'h100, 32'h0, 5'd7, 1'b1);

        // Byte / halfword extension
        ram[32'h7] = 8'h80;
        run_op(c_LB, 32'h7, 32'h0, 5'd8, 1'b1);
        run_op(c_LBU, 32'h7, 32'h0, 5'd9, 1'b1);
        ram[32'h3] = 8'h34; ram[32'h4] = 8'h92;
        run_op(c_LH, 32'h3, 32'h0, 5'd10, 1'b1);
        run_op(c_LHU, 32'h3, 32'h0, 5'd11, 1'b1);

        // Halfword store with the grant dropped on the second byte
        grant_full();
        g[2] = 0; g[3] = 0;
        run_op(c_SH, 32'h201, 32'hDEAD_BEEF, 5'd12, 1'b1);

        // Word store across the address wrap, then read it back
        grant_full();
        run_op(c_SW, 32'hFFFF_FFFE, 32'h1122_3344, 5'd13, 1'b1);
        run_op(c_LW, 32'hFFFF_FFFE, 32'h0, 5'd14, 1'b1);

        // Load targeting x0: access happens, writeback suppressed
        run_op(c_LW, 32'h100, 32'h0, 5'd0, 1'b1);

        // Reset during the third access cycle of a word store
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        aluop_i    = c_SW;
        mem_addr_i = 32'h300;
        wdata_i    = 32'hA1B2_C3D4;
        wd_i       = 5'd15;
        wreg_i     = 1'b1;
        mem_gnt_i  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        aluop_i = c_NOP;
        wreg_i  = 1'b0;
        #1;
        chk("post_rst_stall", {31'd0, stall_req_o}, 32'd0);
        chk("post_rst_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_n_writes", 32'(wr_a.size()), 32'd2);
        run_op(c_LW, 32'h300, 32'h0, 5'd16, 1'b1);

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            op = ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 2))
                0:       a = 32'h100 + 32'($urandom_range(0, 15));
                1:       a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                default: a = 32'h200 + 32'($urandom_range(0, 15));
            endcase
            grant_rand();
            run_op(op, a, $urandom, 5'($urandom), ($urandom_range(0, 4) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
